song_reader: RTL and testbench
==============================

// Module: song_reader
// PURPOSE
//  Sequences the note player for the music player: walks the note ROM of the song selected by mcu,
//  fetches one {note,duration} entry at a time, hands it to note_player with a one-cycle new_note
//  pulse, waits for note_done, and pulses song_done to mcu at end of song. Sits between mcu
//  (play/song in, song_done out), the song ROM (addr out, data in) and note_player.
// PARAMETERS
//  SONG_W  2   song select width (4 songs)
//  IDX_W   5   note index width; NOTES_PER_SONG = 2**IDX_W = 32
//  NOTE_W  6   note code width
//  DUR_W   6   duration width; duration==0 is the end-of-song marker
// PORTS
//  clk        in   1                 system clock; single clock domain
//  reset      in   1                 synchronous, active-high reset
//  play       in   1                 from mcu: 1 = playing, 0 = paused
//  song       in   SONG_W            from mcu: selected song
//  note_done  in   1                 from note_player: 1-cycle pulse, current note finished
//  rom_addr   out  SONG_W+IDX_W      {song, note_index}; sync ROM, data valid 1 cycle after addr
//  rom_data   in   NOTE_W+DUR_W      {note, duration}
//  note       out  NOTE_W            registered note to note_player
//  duration   out  DUR_W             registered duration to note_player
//  new_note   out  1                 1-cycle pulse: note/duration valid, start playing
//  song_done  out  1                 1-cycle pulse to mcu: song finished
// BEHAVIOUR
//  Reset: state IDLE, note_index=0, note=0, duration=0, new_note=0, song_done=0, song_q=song.
//  rom_addr = {song, note_index} combinationally; all other outputs are registered.
//  FSM states: IDLE, FETCH, CAPTURE, ISSUE, WAIT, END.
//   IDLE:    play=1 -> FETCH; else stay (pause between notes keeps note_index).
//   FETCH:   ROM latency cycle -> CAPTURE (unconditional).
//   CAPTURE: latch rom_data into note/duration; duration==0 -> END, else -> ISSUE.
//   ISSUE:   new_note=1 this cycle only -> WAIT.
//   WAIT:    note_done=1 -> if note_index==2**IDX_W-1 -> END, else note_index+1 -> IDLE.
//            play=0 does not leave WAIT (note_player holds the note paused); note_done still taken.
//   END:     song_done=1 this cycle only; note_index<=0 -> IDLE.
//  Latency: play sampled high in IDLE at edge k -> new_note high during cycle after edge k+2.
//  Next note after note_done (play=1): 4 cycles from note_done sample to new_note.
//  note/duration hold their value until next CAPTURE (stable while note_player plays).
//  note_done outside WAIT: ignored. play toggling in FETCH/CAPTURE/ISSUE: fetch completes.
//  Song change: song_q registers song every cycle; song!=song_q in any state -> note_index<=0,
//   note<=0, duration<=0, state IDLE, no new_note, no song_done. Priority: reset > song change > FSM.
//  Index wrap: last index finishing goes to END (never silently wraps to 0 without song_done).
//  END marker and last index are equivalent: both yield exactly one song_done pulse.
//  Reset mid-note: immediate return to reset state; note_player is reset separately by mcu.
// STRUCTURE
//  Shared package: state encoding localparams (S_IDLE..S_END, 3 bits), SONG_W/IDX_W/NOTE_W/DUR_W
//   defaults, end-marker constant DUR_END=0; reused by mcu, note_player and benches.
//  One sub-module: note_index_counter (IDX_W bits, sync clear, enable, last flag).
//  FSM next-state logic and output registers in song_reader itself; no other hierarchy.
// TESTING
//  1 Reset, play=0 for 10 cycles -> new_note=0, song_done=0, rom_addr={song,5'd0}, note=0.
//  2 song=1, ROM[1,0]={6'd20,6'd8}, play=1 at edge k -> new_note pulse in cycle k+3, note=20,
//    duration=8, rom_addr=7'd32; one pulse only.
//  3 Pulse note_done in WAIT with play=1 -> next new_note 4 cycles later with rom_addr=7'd33;
//    with play=0 -> no new_note until play=1, then 3 cycles later, index unchanged at 1.
//  4 ROM[0,2].duration=0, play song 0 -> after note_done of index 1, song_done pulses exactly
//    once, no new_note for index 2, rom_addr returns to 7'd0.
//  5 Song of 32 nonzero entries -> exactly 32 new_note pulses, then one song_done; no wrap replay.
//  6 Change song 0->2 while in WAIT at index 5 -> next cycle state IDLE, note=0, rom_addr=7'd64,
//    no song_done; note_done pulse afterwards ignored.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared constants for the music player: field widths, FSM encoding and end-of-song marker.
// Imported by song_reader, its interface, and by neighbouring blocks and benches.
package song_reader_pkg;

  localparam int unsigned SONG_W = 2;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;

  localparam int unsigned ADDR_W = SONG_W + IDX_W;
  localparam int unsigned DATA_W = NOTE_W + DUR_W;

  // A zero duration terminates a song early.
  localparam logic [DUR_W-1:0] DUR_END = '0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;

  typedef enum logic [2:0] {
    StIdle    = S_IDLE,
    StFetch   = S_FETCH,
    StCapture = S_CAPTURE,
    StIssue   = S_ISSUE,
    StWait    = S_WAIT,
    StEnd     = S_END
  } state_e;

endpackage

// File: rtl/song_reader_if.sv
// Bundles the song_reader's connections to mcu, song ROM and note_player.
// slave is the song_reader's view; master is the surrounding system's view.
interface song_reader_if;
  import song_reader_pkg::*;

  logic              play;
  logic [SONG_W-1:0] song;
  logic              note_done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  modport master (
    output play,
    output song,
    output note_done,
    output rom_data,
    input  rom_addr,
    input  note,
    input  duration,
    input  new_note,
    input  song_done
  );

  modport slave (
    input  play,
    input  song,
    input  note_done,
    input  rom_data,
    output rom_addr,
    output note,
    output duration,
    output new_note,
    output song_done
  );

endinterface

// File: rtl/song_reader_note_index_counter.sv
// Note index within the current song: synchronous clear beats enable, o_last flags the
// final slot so the caller can end the song instead of wrapping.
module song_reader_note_index_counter #(
  parameter int unsigned IdxW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [IdxW-1:0] o_idx,
  output logic            o_last
);

  logic [IdxW-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= r_idx + IdxW'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = &r_idx;

endmodule

// File: rtl/song_reader.sv
// Walks the selected song's ROM one {note,duration} entry at a time, hands each note to
// note_player with a one-cycle new_note pulse and reports end of song with song_done.
module song_reader
  import song_reader_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  song_reader_if.slave bus
);

  state_e            r_state;
  state_e            w_state_next;
  logic [SONG_W-1:0] r_song_q;
  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_duration;
  logic              r_new_note;
  logic              r_song_done;

  logic              w_song_change;
  logic              w_idx_clr;
  logic              w_idx_en;
  logic              w_idx_last;
  logic [IDX_W-1:0]  w_idx;
  logic [NOTE_W-1:0] w_rom_note;
  logic [DUR_W-1:0]  w_rom_dur;

  assign w_song_change           = (bus.song != r_song_q);
  assign {w_rom_note, w_rom_dur} = bus.rom_data;

  // END rewinds for the next play-through; a song change restarts the new song.
  assign w_idx_clr = w_song_change || (r_state == StEnd);
  assign w_idx_en  = (r_state == StWait) && bus.note_done && !w_idx_last;

  song_reader_note_index_counter #(
    .IdxW (IDX_W)
  ) u_idx_counter (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_idx_clr),
    .i_en   (w_idx_en),
    .o_idx  (w_idx),
    .o_last (w_idx_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (bus.play) w_state_next = StFetch;
      StFetch:   w_state_next = StCapture;
      StCapture: w_state_next = (w_rom_dur == DUR_END) ? StEnd : StIssue;
      StIssue:   w_state_next = StWait;
      StWait: begin
        // play is deliberately ignored here: note_player pauses the note itself.
        if (bus.note_done) w_state_next = w_idx_last ? StEnd : StIdle;
      end
      StEnd:     w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
    if (w_song_change) w_state_next = StIdle;
  end

  // Pulses are registered off the next state so they line up with ISSUE and END.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_song_q    <= bus.song;
      r_note      <= '0;
      r_duration  <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_song_q    <= bus.song;
      r_new_note  <= (w_state_next == StIssue);
      r_song_done <= (w_state_next == StEnd);
      if (w_song_change) begin
        r_note     <= '0;
        r_duration <= '0;
      end else if (r_state == StCapture) begin
        r_note     <= w_rom_note;
        r_duration <= w_rom_dur;
      end
    end
  end

  assign bus.rom_addr  = {bus.song, w_idx};
  assign bus.note      = r_note;
  assign bus.duration  = r_duration;
  assign bus.new_note  = r_new_note;
  assign bus.song_done = r_song_done;

  a_new_note_pulse: assert property (@(posedge clk) disable iff (reset)
    r_new_note |=> !r_new_note);
  a_song_done_pulse: assert property (@(posedge clk) disable iff (reset)
    r_song_done |=> !r_song_done);
  a_pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(r_new_note && r_song_done));

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: synchronous ROM model, negedge sampling, pulse counters.
module tb_song_reader;
  import song_reader_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   nn_cnt;
  int   sd_cnt;

  logic [DATA_W-1:0] rom [0:127];

  song_reader_if bus ();

  song_reader u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.new_note === 1'b1) nn_cnt++;
    if (bus.song_done === 1'b1) sd_cnt++;
  endtask

  task automatic pulse_done();
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
  endtask

  task automatic wait_nn(input int bound, input string tag);
    int n = 0;
    while (bus.new_note !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    assert (bus.new_note === 1'b1) else begin
      errors++;
      $error("FAIL %s new_note observed=%0d expected=1", tag, bus.new_note);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nn_cnt = 0;
    sd_cnt = 0;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0]  = {6'd10, 6'd3};
    rom[1]  = {6'd11, 6'd4};
    rom[2]  = {6'd12, 6'd0};
    rom[32] = {6'd20, 6'd8};
    rom[33] = {6'd21, 6'd9};
    rom[34] = {6'd22, 6'd10};
    for (int i = 0; i < 32; i++) rom[64+i] = {6'(i + 1), 6'd1};

    reset         = 1'b1;
    bus.play      = 1'b0;
    bus.song      = 2'd0;
    bus.note_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // 1: idle after reset with play low
    nn_cnt = 0;
    sd_cnt = 0;
    repeat (10) tick();
    check("rst_new_note_cnt", nn_cnt, 0);
    check("rst_song_done_cnt", sd_cnt, 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_note", 32'(bus.note), 32'd0);
    check("rst_duration", 32'(bus.duration), 32'd0);

    // 2: first note of song 1, new_note two edges after the play sample
    bus.song = 2'd1;
    tick();
    check("s1_addr_idle", 32'(bus.rom_addr), 32'd32);
    nn_cnt = 0;
    bus.play = 1'b1;
    tick();
    check("s1_fetch_nn", 32'(bus.new_note), 32'd0);
    tick();
    check("s1_capture_nn", 32'(bus.new_note), 32'd0);
    check("s1_capture_note_old", 32'(bus.note), 32'd0);
    tick();
    check("s1_issue_nn", 32'(bus.new_note), 32'd1);
    check("s1_note", 32'(bus.note), 32'd20);
    check("s1_duration", 32'(bus.duration), 32'd8);
    check("s1_addr", 32'(bus.rom_addr), 32'd32);
    tick();
    check("s1_wait_nn", 32'(bus.new_note), 32'd0);
    check("s1_one_pulse", nn_cnt, 1);

    // 3a: note_done with play high -> next note four cycles later
    pulse_done();
    check("s1_addr_next", 32'(bus.rom_addr), 32'd33);
    tick();
    tick();
    check("s1_next_early", 32'(bus.new_note), 32'd0);
    tick();
    check("s1_next_nn", 32'(bus.new_note), 32'd1);
    check("s1_next_note", 32'(bus.note), 32'd21);
    check("s1_next_dur", 32'(bus.duration), 32'd9);

    // 3b: note_done while paused -> wait in IDLE until play returns
    tick();
    bus.play = 1'b0;
    pulse_done();
    nn_cnt = 0;
    repeat (5) tick();
    check("pause_no_nn", nn_cnt, 0);
    check("pause_addr", 32'(bus.rom_addr), 32'd34);
    bus.play = 1'b1;
    tick();
    check("resume_fetch_nn", 32'(bus.new_note), 32'd0);
    tick();
    check("resume_capture_nn", 32'(bus.new_note), 32'd0);
    tick();
    check("resume_nn", 32'(bus.new_note), 32'd1);
    check("resume_note", 32'(bus.note), 32'd22);

    // 4: end marker at song 0 index 2
    bus.song = 2'd0;
    tick();
    wait_nn(8, "s0_idx0");
    check("s0_note0", 32'(bus.note), 32'd10);
    tick();
    pulse_done();
    wait_nn(8, "s0_idx1");
    check("s0_note1", 32'(bus.note), 32'd11);
    check("s0_addr1", 32'(bus.rom_addr), 32'd1);
    tick();
    nn_cnt = 0;
    sd_cnt = 0;
    pulse_done();
    tick();
    tick();
    tick();
    check("s0_song_done", 32'(bus.song_done), 32'd1);
    bus.play = 1'b0;
    tick();
    check("s0_done_cleared", 32'(bus.song_done), 32'd0);
    check("s0_addr_rewind", 32'(bus.rom_addr), 32'd0);
    check("s0_marker_dur", 32'(bus.duration), 32'd0);
    repeat (4) tick();
    check("s0_sd_once", sd_cnt, 1);
    check("s0_no_idx2_nn", nn_cnt, 0);

    // 5: full 32-entry song, last index ends the song without replay
    bus.song = 2'd2;
    bus.play = 1'b1;
    nn_cnt = 0;
    sd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      wait_nn(10, "s2_nn");
      check("s2_note", 32'(bus.note), 32'(i + 1));
      tick();
      pulse_done();
    end
    check("s2_last_song_done", 32'(bus.song_done), 32'd1);
    bus.play = 1'b0;
    repeat (4) tick();
    check("s2_nn_total", nn_cnt, 32);
    check("s2_sd_total", sd_cnt, 1);
    check("s2_addr_rewind", 32'(bus.rom_addr), 32'd64);

    // 6: song change 0 -> 2 while waiting at index 5
    rom[2] = {6'd12, 6'd5};
    rom[3] = {6'd13, 6'd6};
    rom[4] = {6'd14, 6'd7};
    rom[5] = {6'd15, 6'd2};
    bus.song = 2'd0;
    bus.play = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      wait_nn(10, "chg_nn");
      tick();
      if (i < 5) pulse_done();
    end
    check("chg_wait_addr", 32'(bus.rom_addr), 32'd5);
    check("chg_wait_note", 32'(bus.note), 32'd15);
    bus.play = 1'b0;
    tick();
    nn_cnt = 0;
    sd_cnt = 0;
    bus.song = 2'd2;
    tick();
    check("chg_note", 32'(bus.note), 32'd0);
    check("chg_duration", 32'(bus.duration), 32'd0);
    check("chg_addr", 32'(bus.rom_addr), 32'd64);
    pulse_done();
    repeat (4) tick();
    check("chg_addr_after_done", 32'(bus.rom_addr), 32'd64);
    check("chg_no_nn", nn_cnt, 0);
    check("chg_no_sd", sd_cnt, 0);

    // 7: reset while a note is playing
    bus.play = 1'b1;
    wait_nn(8, "rst_mid_nn");
    check("rst_mid_note_pre", 32'(bus.note), 32'd1);
    tick();
    pulse_done();
    wait_nn(8, "rst_mid_nn2");
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    bus.play = 1'b0;
    check("rst_mid_note", 32'(bus.note), 32'd0);
    check("rst_mid_addr", 32'(bus.rom_addr), 32'd64);
    nn_cnt = 0;
    repeat (4) tick();
    check("rst_mid_no_nn", nn_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
